// File: rtl/rgmii_tx_framer_pkg.sv
// Shared Ethernet/CRC constants and the framer state encoding.
package rgmii_tx_framer_pkg;

  localparam logic [7:0]  ETH_PRE         = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Byte counter: 11 bits, saturating, covers the longest legal frame.
  localparam int          CNT_W   = 11;
  localparam logic [10:0] CNT_MAX = 11'd2047;

  // Last preamble index: the IDLE exit cycle emits byte 0, PREAMBLE emits 1..7.
  localparam logic [7:0]  PRE_LAST = 8'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_PAD      = 3'd3,
    ST_FCS      = 3'd4,
    ST_DROP     = 3'd5,
    ST_IFG      = 3'd6
  } state_e;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational byte-serial CRC-32 (IEEE, reflected); shared with the RX checker.
module eth_crc32_byte
  import rgmii_tx_framer_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Fold one byte in, LSB first, one polynomial step per bit.
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// Gigabit RGMII transmit framer: preamble/SFD, padding, FCS, IFG and
// per-cycle rise/fall nibble pairs for external ODDR output registers.
module rgmii_tx_framer
  import rgmii_tx_framer_pkg::*;
#(
  parameter bit ENABLE_PADDING   = 1'b1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] txd_rise,
  output logic [3:0] txd_fall,
  output logic       tx_ctl_rise,
  output logic       tx_ctl_fall,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [CNT_W-1:0] PAD_LEN  = CNT_W'(MIN_FRAME_LENGTH - 4);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES - 1);

  state_e            state_q, state_d;
  logic [7:0]        aux_q, aux_d;      // preamble index / FCS index / IFG count
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic              tuser_q, tuser_d;

  logic [7:0]        byte_q, byte_d;
  logic              en_q, en_d;
  logic              fall_q, fall_d;
  logic              sp_q, sp_d;
  logic              uf_q, uf_d;
  logic              rdy_q, rdy_d;

  logic              er_d;
  logic [7:0]        crc_data;
  logic [31:0]       crc_next;
  logic [31:0]       fcs_word;
  logic [CNT_W-1:0]  cnt_inc;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_next)
  );

  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign fcs_word = ~crc_q;

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    aux_d    = aux_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    tuser_d  = tuser_q;
    byte_d   = 8'h00;
    en_d     = 1'b0;
    er_d     = 1'b0;
    sp_d     = 1'b0;
    uf_d     = 1'b0;
    crc_data = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = ST_PREAMBLE;
          aux_d   = 8'd1;
          byte_d  = ETH_PRE;
          en_d    = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        en_d = 1'b1;
        if (aux_q == PRE_LAST) begin
          byte_d  = ETH_SFD;
          sp_d    = 1'b1;
          crc_d   = CRC32_INIT;
          cnt_d   = '0;
          state_d = ST_PAYLOAD;
        end else begin
          byte_d = ETH_PRE;
          aux_d  = aux_q + 8'd1;
        end
      end
      ST_PAYLOAD: begin
        en_d = 1'b1;
        if (s_axis_tvalid) begin
          byte_d   = s_axis_tdata;
          crc_data = s_axis_tdata;
          crc_d    = crc_next;
          cnt_d    = cnt_inc;
          if (s_axis_tlast) begin
            tuser_d = s_axis_tuser;
            aux_d   = 8'd0;
            state_d = (ENABLE_PADDING && (cnt_inc < PAD_LEN)) ? ST_PAD : ST_FCS;
          end
        end else begin
          // Stream starved mid-frame: poison the current byte and abandon.
          er_d    = 1'b1;
          uf_d    = 1'b1;
          state_d = ST_DROP;
        end
      end
      ST_PAD: begin
        en_d  = 1'b1;
        crc_d = crc_next;
        cnt_d = cnt_inc;
        if (cnt_inc >= PAD_LEN) begin
          aux_d   = 8'd0;
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        en_d = 1'b1;
        er_d = tuser_q;
        case (aux_q[1:0])
          2'd0:    byte_d = fcs_word[7:0];
          2'd1:    byte_d = fcs_word[15:8];
          2'd2:    byte_d = fcs_word[23:16];
          default: byte_d = fcs_word[31:24];
        endcase
        if (aux_q == 8'd3) begin
          aux_d   = 8'd0;
          state_d = ST_IFG;
        end else begin
          aux_d = aux_q + 8'd1;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          aux_d   = 8'd0;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (aux_q == IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          aux_d = aux_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fall_d = en_d ^ er_d;
    rdy_d  = (state_d == ST_PAYLOAD) || (state_d == ST_DROP);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      aux_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= CRC32_INIT;
      tuser_q <= 1'b0;
      byte_q  <= '0;
      en_q    <= 1'b0;
      fall_q  <= 1'b0;
      sp_q    <= 1'b0;
      uf_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      aux_q   <= aux_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      tuser_q <= tuser_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      fall_q  <= fall_d;
      sp_q    <= sp_d;
      uf_q    <= uf_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s_axis_tready   = rdy_q;
  assign txd_rise        = byte_q[3:0];
  assign txd_fall        = byte_q[7:4];
  assign tx_ctl_rise     = en_q;
  assign tx_ctl_fall     = fall_q;
  assign start_packet    = sp_q;
  assign error_underflow = uf_q;

endmodule
